vic_prio: RTL
=============

Name: vic_prio

Overview:
- Parametrised vectored interrupt controller for the vm1 CPU bus.
- Generalises the fixed 2-channel vectored controller to NUM channels.
- Adds per-channel edge/level mode, a runtime mask, a fixed-priority arbiter, a spurious-vector response and a per-channel pending readback.
- Sits between interrupt sources (keyboard, timer, disk) and the CPU pins virq, iako and rply; the vector is returned on the shared data-in OR-bus.

Parameters:
- NUM, 4: number of interrupt channels, 1..16.
- EDGE, all ones (NUM bits): per-channel mode. 1 = rising-edge latched; 0 = level (pending follows ireq).
- SPURIOUS, 16'o000000: vector returned when acknowledge finds nothing pending.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ce  in  1  bus clock enable. All state advances only when ce=1.
- ireq  in  NUM  request lines from the sources.
- mask  in  NUM  1 = channel disabled for irq_o and for arbitration.
- ivec  in  16*NUM  vectors; channel k occupies [16k+15:16k].
- stb_i  in  1  acknowledge strobe (iako & din).
- irq_o  out  1  vectored interrupt request to the CPU.
- dat_o  out  16  vector; 0 when not acknowledging.
- ack_o  out  1  reply to the CPU.
- iack  out  NUM  one-ce-cycle acknowledge pulse to the winning source.
- pending  out  NUM  pending register, for debug and status reads.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge, regardless of ce): all of the following clear to 0, taking effect the same edge; this aborts any handshake in progress.
  - pending, the ireq sampling register, iack, ack_o, dat_o, irq_o.
  - The FSM returns to IDLE.
- Sampling, each ce cycle:
  - req_q <= ireq.
  - Edge channel k: set = ireq[k] & ~req_q[k]. It is held until cleared by its own acknowledge.
  - Level channel k: pending[k] <= ireq[k].
  - If a set and an acknowledge-clear hit the same edge channel in the same ce cycle, the set wins and pending stays 1.
- irq_o:
  - Registered on ce: irq_o <= |(pending & ~mask) while the FSM is in IDLE.
  - Forced to 0 in ACK and REL.
  - Latency from an ireq edge to irq_o is 2 ce cycles.
- Arbiter: combinational over pending & ~mask. The highest index wins (fixed priority); ties are impossible.
- FSM (advances on ce only):
  - IDLE:
    - On stb_i=1: latch the winner w.
    - dat_o <= ivec[w], or SPURIOUS if there is no candidate.
    - ack_o <= 1.
    - iack[w] <= 1 for one ce cycle (no pulse if spurious).
    - Clear pending[w] if w is an edge channel.
    - Go to ACK.
  - ACK:
    - iack <= 0.
    - Hold dat_o and ack_o.
    - On stb_i=0: ack_o <= 0, dat_o <= 0, go to REL.
  - REL: go to IDLE after one ce cycle; this is the recovery gap that prevents back-to-back capture in the same strobe.
- Winner lock: a request arriving or a mask change during ACK does not alter dat_o.
- Level channels: the source must drop ireq on its iack. Otherwise it re-requests after REL.
- mask does not clear pending. Unmasking a latched edge channel raises irq_o 1 ce cycle later.
- When ce=0: all outputs hold their values and no edges are detected. An edge shorter than the ce period may be missed; that is the source's responsibility.

Decomposition:
- Package vic_pkg:
  - FSM state enum (IDLE, ACK, REL).
  - SPURIOUS default.
  - Function prio_enc(NUM-bit) returning the index and a valid flag.
- Sub-module vic_prio_arb: the parametrised priority encoder (highest index wins), instantiated once. It is reusable by the disk DMA arbiter.
- Everything else stays in vic_prio.

Test Plan:
1. Reset and single request
   - Stimulus: NUM=4, ivec = {o274, o100, o60, o4}, reset_n low then high; pulse ireq[1] for 1 ce.
   - Response: irq_o=1 after 2 ce.
   - Then stb_i high: ack_o=1, dat_o=o60, iack=4'b0010 for exactly 1 ce, pending[1]=0.
   - Then drop stb_i: ack_o=0, dat_o=0, irq_o=0.
2. Priority
   - Stimulus: edges on ireq[0] and ireq[3] in the same ce, then two full acknowledge cycles.
   - Response: first dat_o=o274 with iack[3]; second dat_o=o4 with iack[0]; irq_o=0 afterwards.
3. Mask
   - Stimulus: mask=4'b1000, edge on ireq[3].
   - Response: irq_o stays 0 and pending[3]=1.
   - Then clear mask: irq_o=1 after 1 ce; acknowledge returns o274.
4. Spurious
   - Stimulus: stb_i with pending=0.
   - Response: dat_o=SPURIOUS (0), ack_o=1, iack=0.
5. Set/clear collision and winner lock
   - Stimulus: a new edge on ireq[2] in the same ce as its acknowledge.
   - Response: pending[2] stays 1 and a second acknowledge returns o100.
   - During ACK, raise ireq[3]: dat_o stays o100.
6. Reset mid-handshake and level mode
   - Stimulus: reset_n low while in ACK.
   - Response: next edge ack_o=0, dat_o=0, pending=0, FSM in IDLE.
   - Level mode (EDGE=4'b1110): ireq[0] held high keeps irq_o=1; deasserting it clears pending[0] after 1 ce.

Source files
------------

// File: rtl/vic_pkg.sv
// Shared types for the vectored interrupt controller: handshake FSM states,
// the default spurious vector and the fixed-priority encoder helper.
package vic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    REL  = 2'd2
  } vic_state_e;

  localparam int          MAX_NUM      = 16;
  localparam logic [15:0] SPURIOUS_DEF = 16'o000000;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // Highest set bit wins; later iterations override earlier ones.
  function automatic prio_t prio_enc(input logic [MAX_NUM-1:0] req);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vic_prio_if.sv
// CPU-side acknowledge bus of the vectored interrupt controller.
//
// Handshake: stb_i is the request (valid), ack_o the reply (ready). The CPU
// raises stb_i and holds it until it sees ack_o; dat_o is valid while ack_o
// is high. The CPU then drops stb_i and the controller drops ack_o and dat_o
// on the next bus cycle, followed by a one-cycle gap before the next capture.
interface vic_prio_if;
  logic        stb_i;
  logic        irq_o;
  logic [15:0] dat_o;
  logic        ack_o;

  modport master (
    output stb_i,
    input  irq_o,
    input  dat_o,
    input  ack_o
  );

  modport slave (
    input  stb_i,
    output irq_o,
    output dat_o,
    output ack_o
  );
endinterface

// File: rtl/vic_prio_arb.sv
// Parametrised fixed-priority encoder: the highest-index active request wins.
// Also used by the disk DMA arbiter.
module vic_prio_arb
  import vic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  prio_t res;

  always_comb begin
    res = prio_enc(16'(req));
  end

  assign valid = res.valid;
  assign idx   = res.idx;

endmodule

// File: rtl/vic_prio.sv
// Vectored interrupt controller for the vm1 bus: NUM channels with per-channel
// edge/level capture, runtime mask, fixed priority and spurious vector.
module vic_prio
  import vic_pkg::*;
#(
  parameter int              NUM      = 4,
  parameter logic [NUM-1:0]  EDGE     = '1,
  parameter logic [15:0]     SPURIOUS = SPURIOUS_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [NUM-1:0]    ireq,
  input  logic [NUM-1:0]    mask,
  input  logic [16*NUM-1:0] ivec,
  vic_prio_if.slave         bus,
  output logic [NUM-1:0]    iack,
  output logic [NUM-1:0]    pending,
  output vic_state_e        state
);

  vic_state_e     state_q, state_d;
  logic [NUM-1:0] req_q, pending_q, pending_d;
  logic [NUM-1:0] iack_q, iack_d;
  logic [NUM-1:0] cand, set_edge, clr, win_onehot;
  logic           irq_q, irq_d, ack_q, ack_d;
  logic [15:0]    dat_q, dat_d, win_vec;
  logic           win_valid;
  logic [3:0]     win_idx;

  assign cand = pending_q & ~mask;

  vic_prio_arb #(.N(NUM)) u_arb (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign win_onehot = win_valid ? (NUM'(1) << win_idx) : '0;

  always_comb begin
    win_vec = SPURIOUS;
    for (int k = 0; k < NUM; k++) begin
      if (win_valid && (win_idx == 4'(k))) begin
        win_vec = ivec[16*k +: 16];
      end
    end
  end

  // A fresh edge on a channel being acknowledged wins over the clear.
  assign set_edge  = ireq & ~req_q;
  assign pending_d = (EDGE & ((pending_q & ~clr) | set_edge)) | (~EDGE & ireq);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    iack_d  = '0;
    clr     = '0;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.stb_i) begin
          ack_d   = 1'b1;
          dat_d   = win_vec;
          iack_d  = win_onehot;
          clr     = win_onehot & EDGE;
          state_d = ACK;
        end else begin
          irq_d = |cand;
        end
      end
      ACK: begin
        if (!bus.stb_i) begin
          ack_d   = 1'b0;
          dat_d   = '0;
          state_d = REL;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      iack_q    <= '0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      req_q     <= ireq;
      pending_q <= pending_d;
      iack_q    <= iack_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign bus.irq_o = irq_q;
  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;
  assign iack      = iack_q;
  assign pending   = pending_q;
  assign state     = state_q;

endmodule
